segasys1_sndlatch: RTL and testbench

SEGASYS1_SNDLATCH -- requirements
Module: segasys1_sndlatch

---
 rtl/segasys1_snd_pkg.sv | 16 +
 rtl/segasys1_cmdfifo.sv | 64 ++++++
 rtl/segasys1_sndlatch.sv | 174 +++++++++++++++++
 tb/tb_segasys1_sndlatch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/segasys1_snd_pkg.sv
// Shared types and widths for the System 1 sound command latch.
//   snd_state_t : NMI sequencer states
//   CMD_W       : command byte width
//   CNT_W       : NMI pulse counter width
package segasys1_snd_pkg;

    localparam int CMD_W = 8;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        WAIT_RD = 2'd2
    } snd_state_t;

endpackage

// File: rtl/segasys1_cmdfifo.sv
// Small command FIFO between the main CPU and the sound CPU.
// Ports:
//   clk48M, reset_n : clock, asynchronous active-low reset
//   push, din       : enqueue din (dropped when full, unless popping the same cycle)
//   pop             : dequeue head (ignored when empty)
//   dout            : combinational head entry
//   empty, full     : occupancy flags
module segasys1_cmdfifo
    import segasys1_snd_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic             clk48M,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic [CMD_W-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // When full, a push is accepted only if the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/segasys1_sndlatch.sv
// Sound command latch for the Sega System 1 sound CPU.
// The main CPU writes a command byte on the rising edge of wr_req; the sound
// CPU is interrupted with a fixed-length active-low NMI and reads the byte.
// Build option: define SEGASYS1_SNDFIFO_EN to replace the single latch with a
// 2^FIFO_AW-entry FIFO (segasys1_cmdfifo).
// Ports:
//   clk48M, reset_n : clock, asynchronous active-low reset
//   snd_ce          : sound-CPU clock enable, times the NMI pulse
//   wr_req, wr_data : main-CPU sound request (level) and command byte
//   rd_strobe       : sound-CPU read of the command port
//   rd_data         : current command byte
//   nmi_n           : active-low NMI to the sound CPU
//   pending         : at least one unread command held
//   overrun         : sticky, a command arrived while storage was full
//
// state   | meaning
// IDLE    | no NMI in progress; start one when a command is pending
// PULSE   | nmi_n low, counting NMI_WIDTH snd_ce ticks
// WAIT_RD | pulse finished, waiting for the sound CPU to read the command
module segasys1_sndlatch
    import segasys1_snd_pkg::*;
#(
    parameter int NMI_WIDTH = 32,
    parameter int FIFO_AW   = 2
) (
    input  logic             clk48M,
    input  logic             reset_n,
    input  logic             snd_ce,
    input  logic             wr_req,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             rd_strobe,
    output logic [CMD_W-1:0] rd_data,
    output logic             nmi_n,
    output logic             pending,
    output logic             overrun
);

    if (NMI_WIDTH < 1 || NMI_WIDTH > 255 || FIFO_AW < 1 || FIFO_AW > 8) begin : g_param_check
        $error("segasys1_sndlatch: NMI_WIDTH or FIFO_AW out of range");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NMI_WIDTH - 1);

    snd_state_t       state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             rd_done_q, rd_done_nx;
    logic             wr_q;
    logic             wr_ev;
    logic             rd_ev;
    logic             ovr_set;

    assign wr_ev = wr_req & ~wr_q;
    // Reads with nothing held are ignored entirely.
    assign rd_ev = rd_strobe & pending;

`ifdef SEGASYS1_SNDFIFO_EN
    logic [CMD_W-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CMD_W-1:0] last_q;

    segasys1_cmdfifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk48M  (clk48M),
        .reset_n (reset_n),
        .push    (wr_ev),
        .pop     (rd_ev),
        .din     (wr_data),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign pending = ~fifo_empty;
    assign ovr_set = wr_ev & fifo_full & ~rd_ev;
    // Once drained, the FIFO head slot is stale; show the byte last read instead.
    assign rd_data = pending ? fifo_dout : last_q;

    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= '0;
        end else if (rd_ev) begin
            last_q <= fifo_dout;
        end
    end
`else
    logic [CMD_W-1:0] latch_q;
    logic             pend_q;

    assign pending = pend_q;
    assign ovr_set = wr_ev & pend_q & ~rd_ev;
    assign rd_data = latch_q;

    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            latch_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            if (wr_ev) begin
                latch_q <= wr_data;
            end
            // A write wins over a same-cycle read: the new byte stays pending.
            if (wr_ev) begin
                pend_q <= 1'b1;
            end else if (rd_ev) begin
                pend_q <= 1'b0;
            end
        end
    end
`endif

    always_comb begin
        state_nx   = state_q;
        cnt_nx     = cnt_q;
        rd_done_nx = rd_done_q;
        case (state_q)
            IDLE: begin
                cnt_nx     = '0;
                rd_done_nx = 1'b0;
                if (pending) begin
                    state_nx = PULSE;
                end
            end
            PULSE: begin
                // An early read is remembered so WAIT_RD does not demand another.
                if (rd_ev) begin
                    rd_done_nx = 1'b1;
                end
                if (snd_ce) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_nx   = '0;
                        state_nx = WAIT_RD;
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end
            end
            WAIT_RD: begin
                // !pending covers a command consumed before the pulse started.
                if (rd_done_q || rd_ev || !pending) begin
                    rd_done_nx = 1'b0;
                    state_nx   = IDLE;
                end
            end
            default: begin
                cnt_nx     = '0;
                rd_done_nx = 1'b0;
                state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_done_q <= 1'b0;
            wr_q      <= 1'b0;
            nmi_n     <= 1'b1;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_nx;
            cnt_q     <= cnt_nx;
            rd_done_q <= rd_done_nx;
            wr_q      <= wr_req;
            nmi_n     <= (state_nx != PULSE);
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_segasys1_sndlatch.sv
// Directed bench for segasys1_sndlatch (default latch build, or FIFO build
// when SEGASYS1_SNDFIFO_EN is defined). snd_ce fires every 12 clk48M cycles.
module tb_segasys1_sndlatch;

    logic       clk48M;
    logic       reset_n;
    logic       snd_ce;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       rd_strobe;
    logic [7:0] rd_data;
    logic       nmi_n;
    logic       pending;
    logic       overrun;

    int n_cmp;
    int n_err;
    int ce_div;
    int nmi_falls;
    logic nmi_prev;

    segasys1_sndlatch #(
        .NMI_WIDTH (32),
        .FIFO_AW   (2)
    ) dut (
        .clk48M    (clk48M),
        .reset_n   (reset_n),
        .snd_ce    (snd_ce),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .rd_strobe (rd_strobe),
        .rd_data   (rd_data),
        .nmi_n     (nmi_n),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial begin
        clk48M = 1'b0;
        forever #5 clk48M = ~clk48M;
    end

    initial begin
        snd_ce = 1'b0;
        ce_div = 0;
        forever begin
            @(posedge clk48M);
            #1;
            snd_ce = (ce_div == 11);
            ce_div = (ce_div == 11) ? 0 : ce_div + 1;
        end
    end

    initial begin
        nmi_falls = 0;
        nmi_prev  = 1'b1;
        forever begin
            @(negedge clk48M);
            if (nmi_prev && !nmi_n) nmi_falls++;
            nmi_prev = nmi_n;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk48M);
        #1;
    endtask

    task automatic wait_nmi(input logic lvl, input int budget, input string tag);
        int i;
        i = 0;
        while (nmi_n !== lvl && i < budget) begin
            @(negedge clk48M);
            i++;
        end
        check_val(tag, 32'(nmi_n), 32'(lvl));
    endtask

    // Call at a negedge with nmi_n low; counts snd_ce ticks while it stays low.
    task automatic measure_pulse(output int ticks);
        int cyc;
        cyc   = 0;
        ticks = 0;
        while (nmi_n === 1'b0 && cyc < 2000) begin
            if (snd_ce) ticks++;
            @(negedge clk48M);
            cyc++;
        end
    endtask

    task automatic watch_quiet(input int cycles, input string tag);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk48M);
            if (nmi_n !== 1'b1) lows++;
        end
        check_val(tag, 32'(lows), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] d);
        step();
        wr_data = d;
        wr_req  = 1'b1;
        step();
        wr_req  = 1'b0;
    endtask

    task automatic do_read();
        step();
        rd_strobe = 1'b1;
        step();
        rd_strobe = 1'b0;
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int ticks;
        int base;
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        wr_req    = 1'b0;
        wr_data   = 8'h00;
        rd_strobe = 1'b0;

        // Reset state
        step();
        @(negedge clk48M);
        check_val("rst_nmi_n",   32'(nmi_n),   32'd1);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        check_val("rst_rd_data", 32'(rd_data), 32'h00);
        step();
        reset_n = 1'b1;
        step();
        step();

        // Single command 5A, wr_req held high throughout
        base = nmi_falls;
        step();
        wr_data = 8'h5A;
        wr_req  = 1'b1;
        @(negedge clk48M);
        check_val("pend_cycle_n", 32'(pending), 32'd0);
        step();
        @(negedge clk48M);
        check_val("pend_n1",    32'(pending), 32'd1);
        check_val("nmi_n1",     32'(nmi_n),   32'd1);
        check_val("rd_data_5a", 32'(rd_data), 32'h5A);
        step();
        @(negedge clk48M);
        check_val("nmi_n2_low", 32'(nmi_n), 32'd0);
        measure_pulse(ticks);
        check_val("pulse_ticks", 32'(ticks), 32'd32);
        check_val("pend_wait_rd", 32'(pending), 32'd1);
        watch_quiet(40, "wait_rd_holds");
        check_val("pend_before_rd", 32'(pending), 32'd1);
        do_read();
        @(negedge clk48M);
        check_val("pend_after_rd", 32'(pending), 32'd0);
        watch_quiet(100, "no_second_nmi");
        check_val("held_wr_req_ovr", 32'(overrun), 32'd0);
        step();
        check_val("nmi_count_5a", 32'(nmi_falls - base), 32'd1);
        wr_req = 1'b0;

        // Read with nothing pending is ignored
        do_read();
        @(negedge clk48M);
        check_val("idle_rd_data", 32'(rd_data), 32'h5A);
        check_val("idle_rd_pend", 32'(pending), 32'd0);

`ifndef SEGASYS1_SNDFIFO_EN
        // Latch overwrite, then a read during PULSE
        do_write(8'hA0);
        do_write(8'hA1);
        @(negedge clk48M);
        check_val("latch_ovr",     32'(overrun), 32'd1);
        check_val("latch_rd_a1",   32'(rd_data), 32'hA1);
        check_val("latch_pend",    32'(pending), 32'd1);
        check_val("latch_nmi_low", 32'(nmi_n),   32'd0);
        do_read();
        @(negedge clk48M);
        check_val("early_rd_pend", 32'(pending), 32'd0);
        check_val("early_rd_nmi",  32'(nmi_n),   32'd0);
        wait_nmi(1'b1, 1000, "early_rd_pulse_end");
        watch_quiet(100, "no_nmi_after_early_rd");
`else
        // FIFO fill past depth, then drain in order
        do_reset();
        step();
        base = nmi_falls;
        for (int k = 1; k <= 5; k++) begin
            do_write(8'(k));
        end
        @(negedge clk48M);
        check_val("fifo_ovr",  32'(overrun), 32'd1);
        check_val("fifo_head", 32'(rd_data), 32'h01);
        for (int k = 1; k <= 4; k++) begin
            wait_nmi(1'b0, 1000, "fifo_nmi_low");
            wait_nmi(1'b1, 1000, "fifo_nmi_high");
            check_val("fifo_rd_order", 32'(rd_data), 32'(k));
            do_read();
        end
        @(negedge clk48M);
        check_val("fifo_drained", 32'(pending), 32'd0);
        watch_quiet(600, "fifo_no_fifth_nmi");
        step();
        check_val("fifo_nmi_count", 32'(nmi_falls - base), 32'd4);
`endif

        // Same-cycle write and read, then reset mid-pulse
        do_reset();
        do_write(8'h11);
        wait_nmi(1'b0, 10, "sim_nmi_low");
        step();
        wr_data   = 8'h22;
        wr_req    = 1'b1;
        rd_strobe = 1'b1;
        step();
        wr_req    = 1'b0;
        rd_strobe = 1'b0;
        @(negedge clk48M);
        check_val("sim_pend", 32'(pending), 32'd1);
        check_val("sim_ovr",  32'(overrun), 32'd0);
        check_val("sim_data", 32'(rd_data), 32'h22);
        check_val("sim_nmi",  32'(nmi_n),   32'd0);
        do_write(8'h33);
        @(negedge clk48M);
`ifndef SEGASYS1_SNDFIFO_EN
        check_val("pre_rst_ovr",  32'(overrun), 32'd1);
        check_val("pre_rst_data", 32'(rd_data), 32'h33);
`else
        check_val("pre_rst_ovr",  32'(overrun), 32'd0);
        check_val("pre_rst_data", 32'(rd_data), 32'h22);
`endif
        check_val("pre_rst_nmi", 32'(nmi_n), 32'd0);
        @(posedge clk48M);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_nmi",  32'(nmi_n),   32'd1);
        check_val("async_rst_pend", 32'(pending), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        @(negedge clk48M);
        check_val("post_rst_pend", 32'(pending), 32'd0);
        check_val("post_rst_ovr",  32'(overrun), 32'd0);
        check_val("post_rst_data", 32'(rd_data), 32'h00);
        watch_quiet(60, "post_rst_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
